// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage with ID/EX and EX/MEM registers, ALU, NZCV status and branch resolution
module exe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic [8:0]   ctrl_in,
  input  logic         valid_in,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] val_rn,
  input  logic [W-1:0] val2,
  input  logic [W-1:0] val_rm,
  input  logic [3:0]   dest_in,
  input  logic [23:0]  imm24,
  output logic [3:0]   status_out,
  output logic         branch_taken,
  output logic [W-1:0] branch_addr,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] st_data,
  output logic [3:0]   dest_out,
  output logic         wb_en,
  output logic         mem_r_en,
  output logic         mem_w_en,
  output logic         valid_out
);
  logic [8:0]   r_ctrl;
  logic         r_valid;
  logic [W-1:0] r_pc, r_rn, r_val2, r_rm;
  logic [3:0]   r_dest;
  logic [23:0]  r_imm;
  logic [3:0]   r_nzcv;
  logic [3:0]   w_cmd;
  logic         w_def, w_arith, w_sub, w_cin, w_v, w_go;
  logic [W-1:0] w_bop, w_res;
  logic [W:0]   w_sum;
  logic [3:0]   w_nzcv;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rn    <= '0;
      r_val2  <= '0;
      r_rm    <= '0;
      r_dest  <= '0;
      r_imm   <= '0;
    end else if (flush) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (!freeze) begin
      r_ctrl  <= ctrl_in;
      r_valid <= valid_in;
      r_pc    <= pc_in;
      r_rn    <= val_rn;
      r_val2  <= val2;
      r_rm    <= val_rm;
      r_dest  <= dest_in;
      r_imm   <= imm24;
    end
  end
  assign w_cmd   = r_ctrl[6:3];
  assign w_def   = (w_cmd != 4'd0) && (w_cmd <= 4'd9);
  assign w_arith = (w_cmd >= 4'd2) && (w_cmd <= 4'd5);
  assign w_sub   = w_cmd[3:1] == 3'b010;
  // Subtract is A + ~B + carry-in, so C reads as "no borrow"
  assign w_bop   = w_sub ? ~r_val2 : r_val2;
  assign w_cin   = w_cmd == 4'd2 ? 1'b0 : w_cmd == 4'd4 ? 1'b1 : r_nzcv[1];
  assign w_sum   = {1'b0, r_rn} + {1'b0, w_bop} + {{W{1'b0}}, w_cin};
  assign w_v     = (r_rn[W-1] == w_bop[W-1]) && (w_sum[W-1] != r_rn[W-1]);
  always_comb begin
    w_res = '0;
    case (w_cmd)
      4'd1:                   w_res = r_val2;
      4'd9:                   w_res = ~r_val2;
      4'd2, 4'd3, 4'd4, 4'd5: w_res = w_sum[W-1:0];
      4'd6:                   w_res = r_rn & r_val2;
      4'd7:                   w_res = r_rn | r_val2;
      4'd8:                   w_res = r_rn ^ r_val2;
      default:                w_res = '0;
    endcase
  end
  assign w_nzcv = {w_res[W-1], w_res == '0, w_arith ? w_sum[W] : r_nzcv[1], w_arith ? w_v : r_nzcv[0]};
  always_ff @(posedge clk) begin
    if (rst) r_nzcv <= '0;
    else if (!freeze && r_ctrl[8] && r_valid && w_def) r_nzcv <= w_nzcv;
  end
  assign status_out   = r_nzcv;
  assign branch_taken = r_ctrl[7] & r_valid;
  assign branch_addr  = r_pc + {{(W-26){r_imm[23]}}, r_imm, 2'b00};
  // Branches retire as valid but with no side effects downstream
  assign w_go = r_valid & ~r_ctrl[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      st_data    <= '0;
      dest_out   <= '0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      valid_out  <= 1'b0;
    end else if (!freeze) begin
      alu_result <= w_res;
      st_data    <= r_rm;
      dest_out   <= r_dest;
      wb_en      <= w_go & r_ctrl[0];
      mem_r_en   <= w_go & r_ctrl[1];
      mem_w_en   <= w_go & r_ctrl[2];
      valid_out  <= r_valid;
    end
  end
endmodule
